// File: rtl/alu_pkg.sv
// alu_pkg: op codes and FSM state encoding shared by the ALU control decoder and the execute stage
package alu_pkg;
    localparam logic [3:0] ALU_ADD         = 4'd0;
    localparam logic [3:0] ALU_SUB         = 4'd1;
    localparam logic [3:0] ALU_AND         = 4'd2;
    localparam logic [3:0] ALU_OR          = 4'd3;
    localparam logic [3:0] ALU_XOR         = 4'd4;
    localparam logic [3:0] ALU_NOR         = 4'd5;
    localparam logic [3:0] ALU_SLL         = 4'd6;
    localparam logic [3:0] ALU_SRL         = 4'd7;
    localparam logic [3:0] ALU_ILLEGAL_MIN = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: single-cycle add/sub/and/or/xor/nor with signed overflow; other op codes give 0
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          ovf
);
    logic          sub;
    logic          arith;
    logic [DW-1:0] b_eff;
    logic [DW-1:0] sum;

    assign sub   = op == ALU_SUB;
    assign arith = op == ALU_ADD || sub;
    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + DW'(sub);
    assign res   = arith         ? sum
                 : op == ALU_AND ? a & b
                 : op == ALU_OR  ? a | b
                 : op == ALU_XOR ? a ^ b
                 : op == ALU_NOR ? ~(a | b)
                 : '0;
    assign ovf   = arith && a[DW-1] == b_eff[DW-1] && sum[DW-1] != a[DW-1];
endmodule

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: valid/ready execute-stage ALU with a one-bit-per-cycle iterative shifter
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int DW  = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     alu_ctrl,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [SHW-1:0] shamt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  result,
    output logic           zero,
    output logic           ovf,
    output logic           illegal
);
    state_t         state;
    state_t         state_nx;
    logic [DW-1:0]  sh_reg;
    logic [DW-1:0]  sh_nx;
    logic [DW-1:0]  core_res;
    logic [DW-1:0]  acc_res;
    logic [SHW-1:0] cnt;
    logic           sh_left;
    logic           core_ovf;
    logic           is_shift;
    logic           illegal_op;
    logic           start_shift;
    logic           accept;
    logic           last_shift;

    alu_core_comb #(.DW(DW)) u_core (
        .op  (alu_ctrl),
        .a   (a),
        .b   (b),
        .res (core_res),
        .ovf (core_ovf)
    );

    assign is_shift    = alu_ctrl == ALU_SLL || alu_ctrl == ALU_SRL;
    assign illegal_op  = alu_ctrl >= ALU_ILLEGAL_MIN;
    assign start_shift = is_shift && shamt != '0;
    assign accept      = in_valid && in_ready;
    assign acc_res     = is_shift ? b : core_res;
    assign sh_nx       = sh_left ? sh_reg << 1 : sh_reg >> 1;
    assign last_shift  = state == ST_SHIFT && cnt == SHW'(1);

    // handshake outputs and next state; a completed result may be replaced in the same cycle it is taken
    always_comb begin
        in_ready  = rst_n && (state == ST_IDLE || (state == ST_DONE && out_ready));
        out_valid = rst_n && state == ST_DONE;
        state_nx  = state;
        if (accept) state_nx = start_shift ? ST_SHIFT : ST_DONE;
        else if (state == ST_SHIFT) state_nx = last_shift ? ST_DONE : ST_SHIFT;
        else if (state == ST_DONE && out_ready) state_nx = ST_IDLE;
    end

    // state, shift register/counter and the held result with its flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sh_reg  <= '0;
            cnt     <= '0;
            sh_left <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept && start_shift) begin
                sh_reg  <= b;
                cnt     <= shamt;
                sh_left <= alu_ctrl == ALU_SLL;
            end else if (accept) begin
                result  <= acc_res;
                zero    <= acc_res == '0;
                ovf     <= core_ovf;
                illegal <= illegal_op;
            end else if (state == ST_SHIFT) begin
                sh_reg <= sh_nx;
                cnt    <= cnt - SHW'(1);
                if (last_shift) begin
                    result  <= sh_nx;
                    zero    <= sh_nx == '0;
                    ovf     <= 1'b0;
                    illegal <= 1'b0;
                end
            end
        end
    end
endmodule
